// File: rtl/sram_access_scheduler.sv
// sram_access_scheduler
//   Time-multiplexes a single asynchronous SRAM between a queued command
//   stream (pixel writes / address sets / page flips) and a display read
//   port. A free-running 4-phase counter splits each period into a write
//   slot (phases 0-1) and a read slot (phases 2-3). Two SRAM pages are
//   used: the writer fills `page`, the display reads `~page`.
//
// Ports
//   mco, rst_n            clock, async active-low reset
//   cmd_valid/ready       command handshake
//   cmd_type, cmd_data    00 write pixel {R6,G6,B6}, 01 set address, 10 flip, 11 ignored
//   frame_start           vsync pulse; commits a pending page flip
//   rd_addr               display pixel index (17 bits)
//   rd_data, rd_valid     fetched 16-bit pixel, one-cycle strobe in phase 0
//   sram_*                SRAM address, data bus, output enable, strobes
//   page, disp_enable     current write page, display enabled after first flip
//   fifo_level            command FIFO occupancy
module sram_access_scheduler #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        mco,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [17:0] cmd_data,
    input  logic        frame_start,
    input  logic [16:0] rd_addr,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic [17:0] sram_addr,
    output logic [23:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [23:0] sram_dq_in,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        page,
    output logic        disp_enable,
    output logic [4:0]  fifo_level
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] LEVEL_FULL = 5'(FIFO_DEPTH);
    localparam logic [1:0] T_WRITE = 2'b00;
    localparam logic [1:0] T_ADDR  = 2'b01;
    localparam logic [1:0] T_FLIP  = 2'b10;
    localparam logic [1:0] T_NONE  = 2'b11;

    typedef enum logic [1:0] {
        PH_W0 = 2'd0,
        PH_W1 = 2'd1,
        PH_R0 = 2'd2,
        PH_R1 = 2'd3
    } phase_t;

    phase_t phase, phase_nxt;

    logic [19:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_idx, rd_idx;
    logic [16:0]   wr_ptr;
    logic          flip_pending;

    logic        push, pop, commit, page_nxt;
    logic [19:0] head, la_head;
    logic        la_have, la_flip, la_write;
    logic        unused_bits;

    // Phase counter state machine (free running, wraps 3 -> 0)
    always_ff @(posedge mco or negedge rst_n) begin
        if (!rst_n) phase <= PH_W0;
        else        phase <= phase_nxt;
    end

    always_comb begin
        phase_nxt = PH_W0;
        case (phase)
            PH_W0:   phase_nxt = PH_W1;
            PH_W1:   phase_nxt = PH_R0;
            PH_R0:   phase_nxt = PH_R1;
            default: phase_nxt = PH_W0;
        endcase
    end

    assign cmd_ready = (fifo_level != LEVEL_FULL);
    // Ignored commands complete the handshake but are never stored.
    assign push      = cmd_valid && cmd_ready && (cmd_type != T_NONE);
    assign head      = mem[rd_idx];
    assign pop       = (phase == PH_W0) && (fifo_level != 5'd0) && !flip_pending;
    assign commit    = frame_start && flip_pending;
    assign page_nxt  = page ^ commit;

    // The SRAM strobes are registered, so the write for phase 0 must be
    // decided at the edge ending phase 3. This lookahead predicts exactly
    // what the phase-0 pop will see: FIFO contents after this edge's push
    // (bypassing the incoming command when empty), flip state after this
    // edge's possible commit, and the page after that commit.
    assign la_head  = (fifo_level == 5'd0) ? {cmd_type, cmd_data} : head;
    assign la_have  = (fifo_level != 5'd0) || push;
    assign la_flip  = flip_pending && !frame_start;
    assign la_write = (phase == PH_R1) && la_have && !la_flip &&
                      (la_head[19:18] == T_WRITE);

    assign unused_bits = ^{sram_dq_in[23:16], la_head[12], la_head[0]};

    // FIFO storage: no reset needed, pointers define validity.
    always_ff @(posedge mco) begin
        if (push) mem[wr_idx] <= {cmd_type, cmd_data};
    end

    always_ff @(posedge mco or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx     <= '0;
            rd_idx     <= '0;
            fifo_level <= 5'd0;
        end else begin
            if (push) wr_idx <= wr_idx + 1'b1;
            if (pop)  rd_idx <= rd_idx + 1'b1;
            fifo_level <= fifo_level + 5'(push) - 5'(pop);
        end
    end

    // Command execution at the pop edge; SRAM strobes were already loaded.
    always_ff @(posedge mco or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= 17'd0;
            flip_pending <= 1'b0;
            page         <= 1'b0;
            disp_enable  <= 1'b0;
        end else begin
            if (pop) begin
                case (head[19:18])
                    T_WRITE: wr_ptr       <= wr_ptr + 17'd1;
                    T_ADDR:  wr_ptr       <= head[16:0];
                    T_FLIP:  flip_pending <= 1'b1;
                    default: ;
                endcase
            end
            // pop needs flip_pending=0 and commit needs 1: never both.
            if (commit) begin
                page         <= ~page;
                flip_pending <= 1'b0;
                disp_enable  <= 1'b1;
            end
        end
    end

    // SRAM bus sequencing
    always_ff @(posedge mco or negedge rst_n) begin
        if (!rst_n) begin
            sram_addr   <= 18'd0;
            sram_dq_out <= 24'd0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            rd_data     <= 16'd0;
            rd_valid    <= 1'b0;
        end else begin
            case (phase)
                PH_R1: begin
                    // end of read slot: capture pixel, enter write slot
                    sram_oe_n <= 1'b1;
                    rd_data   <= sram_dq_in[15:0];
                    rd_valid  <= 1'b1;
                    if (la_write) begin
                        sram_addr   <= {page_nxt, wr_ptr};
                        sram_dq_out <= {8'b0, la_head[5:1], la_head[11:6], la_head[17:13]};
                        sram_dq_oe  <= 1'b1;
                        sram_we_n   <= 1'b0;
                    end
                end
                PH_W0: rd_valid <= 1'b0;
                PH_W1: begin
                    // end of write slot: release bus, then read the display page
                    sram_we_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                    sram_oe_n  <= 1'b0;
                    sram_addr  <= {~page_nxt, rd_addr};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_access_scheduler.sv
// tb_sram_access_scheduler
//   Directed bench: each task resets the DUT, steps cycle by cycle from the
//   first phase-0 cycle after reset (C0) and compares outputs against
//   hand-derived values at known cycles.
module tb_sram_access_scheduler;

    logic        mco = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_type = 2'b00;
    logic [17:0] cmd_data = 18'd0;
    logic        frame_start = 1'b0;
    logic [16:0] rd_addr = 17'd0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [17:0] sram_addr;
    logic [23:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [23:0] sram_dq_in = 24'd0;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        page;
    logic        disp_enable;
    logic [4:0]  fifo_level;

    int n_chk = 0;
    int n_ok  = 0;

    sram_access_scheduler #(.FIFO_DEPTH(4)) dut (
        .mco(mco), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_data(cmd_data),
        .frame_start(frame_start), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .page(page), .disp_enable(disp_enable), .fifo_level(fifo_level)
    );

    always #5 mco = ~mco;

    task automatic tick();
        @(posedge mco); #1;
    endtask

    // Leaves the bench in C0: the first phase-0 cycle after release.
    task automatic do_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_type = 2'b00; cmd_data = 18'd0;
        frame_start = 1'b0;
        repeat (3) @(posedge mco);
        #1 rst_n = 1'b1;
    endtask

    task automatic push(input logic [1:0] t, input logic [17:0] d);
        cmd_valid = 1'b1; cmd_type = t; cmd_data = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        n_chk++; if (cmd_ready !== 1'b1)     $display("FAIL rst_ready got %0h exp 1", cmd_ready); else n_ok++;
        n_chk++; if (fifo_level !== 5'd0)    $display("FAIL rst_level got %0h exp 0", fifo_level); else n_ok++;
        n_chk++; if (page !== 1'b0)          $display("FAIL rst_page got %0h exp 0", page); else n_ok++;
        n_chk++; if (disp_enable !== 1'b0)   $display("FAIL rst_disp got %0h exp 0", disp_enable); else n_ok++;
        n_chk++; if (sram_addr !== 18'd0)    $display("FAIL rst_addr got %0h exp 0", sram_addr); else n_ok++;
        n_chk++; if (sram_dq_out !== 24'd0)  $display("FAIL rst_dq got %0h exp 0", sram_dq_out); else n_ok++;
        n_chk++; if (sram_dq_oe !== 1'b0)    $display("FAIL rst_dq_oe got %0h exp 0", sram_dq_oe); else n_ok++;
        n_chk++; if (sram_we_n !== 1'b1)     $display("FAIL rst_we_n got %0h exp 1", sram_we_n); else n_ok++;
        n_chk++; if (sram_oe_n !== 1'b1)     $display("FAIL rst_oe_n got %0h exp 1", sram_oe_n); else n_ok++;
        n_chk++; if (rd_data !== 16'd0)      $display("FAIL rst_rd_data got %0h exp 0", rd_data); else n_ok++;
        n_chk++; if (rd_valid !== 1'b0)      $display("FAIL rst_rd_valid got %0h exp 0", rd_valid); else n_ok++;
        do_reset();
        // type 11 is accepted but not stored
        push(2'b11, 18'h12345);
        n_chk++; if (fifo_level !== 5'd0)    $display("FAIL ignored_level got %0h exp 0", fifo_level); else n_ok++;
        n_chk++; if (cmd_ready !== 1'b1)     $display("FAIL ignored_ready got %0h exp 1", cmd_ready); else n_ok++;
    endtask

    task automatic test_addr_wrap();
        do_reset();
        rd_addr = 17'h00ABC;
        push(2'b01, 18'h1FFFF);                       // -> C1
        push(2'b00, 18'h3FFFF);                       // -> C2
        push(2'b00, 18'h3FFFF);                       // -> C3
        n_chk++; if (fifo_level !== 5'd3)    $display("FAIL wrap_level got %0h exp 3", fifo_level); else n_ok++;
        tick();                                       // C4: address-set slot
        n_chk++; if (sram_we_n !== 1'b1)     $display("FAIL wrap_addrset_we got %0h exp 1", sram_we_n); else n_ok++;
        repeat (4) tick();                            // C8
        n_chk++; if (sram_we_n !== 1'b0)     $display("FAIL wrap_w1_we got %0h exp 0", sram_we_n); else n_ok++;
        n_chk++; if (sram_addr !== 18'h1FFFF) $display("FAIL wrap_w1_addr got %0h exp 1ffff", sram_addr); else n_ok++;
        n_chk++; if (sram_dq_out !== 24'h00FFFF) $display("FAIL wrap_w1_dq got %0h exp ffff", sram_dq_out); else n_ok++;
        n_chk++; if (sram_dq_oe !== 1'b1 || sram_oe_n !== 1'b1)
            $display("FAIL wrap_w1_bus got oe=%0h oe_n=%0h exp 1 1", sram_dq_oe, sram_oe_n); else n_ok++;
        tick();                                       // C9
        n_chk++; if (sram_we_n !== 1'b0)     $display("FAIL wrap_w1_we2 got %0h exp 0", sram_we_n); else n_ok++;
        tick();                                       // C10: read slot
        n_chk++; if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b0 || sram_dq_oe !== 1'b0)
            $display("FAIL wrap_rd_strobes got we_n=%0h oe_n=%0h oe=%0h exp 1 0 0", sram_we_n, sram_oe_n, sram_dq_oe); else n_ok++;
        n_chk++; if (sram_addr !== 18'h20ABC) $display("FAIL wrap_rd_addr got %0h exp 20abc", sram_addr); else n_ok++;
        repeat (2) tick();                            // C12
        n_chk++; if (sram_we_n !== 1'b0)     $display("FAIL wrap_w2_we got %0h exp 0", sram_we_n); else n_ok++;
        n_chk++; if (sram_addr !== 18'h00000) $display("FAIL wrap_w2_addr got %0h exp 0", sram_addr); else n_ok++;
        n_chk++; if (sram_dq_out !== 24'h00FFFF) $display("FAIL wrap_w2_dq got %0h exp ffff", sram_dq_out); else n_ok++;
        tick();                                       // C13
        n_chk++; if (sram_we_n !== 1'b0 || fifo_level !== 5'd0)
            $display("FAIL wrap_w2_end got we_n=%0h level=%0h exp 0 0", sram_we_n, fifo_level); else n_ok++;
        tick();                                       // C14
        n_chk++; if (sram_we_n !== 1'b1)     $display("FAIL wrap_w2_release got %0h exp 1", sram_we_n); else n_ok++;
    endtask

    task automatic test_page_flip();
        int early;
        do_reset();
        rd_addr = 17'h00010;
        push(2'b10, 18'd0);                           // -> C1
        push(2'b00, 18'h3F000);                       // -> C2, red only
        repeat (2) tick();                            // C4: flip slot
        n_chk++; if (sram_we_n !== 1'b1)     $display("FAIL flip_slot_we got %0h exp 1", sram_we_n); else n_ok++;
        early = 0;
        for (int i = 0; i < 11; i++) begin           // C5..C15
            tick();
            if (sram_we_n == 1'b0) early++;
        end
        n_chk++; if (early !== 0)            $display("FAIL flip_held_writes got %0d exp 0", early); else n_ok++;
        n_chk++; if (fifo_level !== 5'd1 || page !== 1'b0 || disp_enable !== 1'b0)
            $display("FAIL flip_before got level=%0h page=%0h disp=%0h exp 1 0 0", fifo_level, page, disp_enable); else n_ok++;
        frame_start = 1'b1;                           // C15, phase 3
        tick();                                       // C16
        frame_start = 1'b0;
        n_chk++; if (page !== 1'b1 || disp_enable !== 1'b1)
            $display("FAIL flip_commit got page=%0h disp=%0h exp 1 1", page, disp_enable); else n_ok++;
        n_chk++; if (sram_we_n !== 1'b0 || sram_addr !== 18'h20000)
            $display("FAIL flip_write got we_n=%0h addr=%0h exp 0 20000", sram_we_n, sram_addr); else n_ok++;
        n_chk++; if (sram_dq_out !== 24'h00001F) $display("FAIL flip_dq got %0h exp 1f", sram_dq_out); else n_ok++;
        repeat (2) tick();                            // C18: reads the other page
        n_chk++; if (sram_addr !== 18'h00010) $display("FAIL flip_rd_addr got %0h exp 10", sram_addr); else n_ok++;
    endtask

    task automatic test_back_to_back();
        int acc, nw, maxlvl;
        logic prev_we, rdy, vld;
        do_reset();
        push(2'b10, 18'd0);
        repeat (4) tick();                            // C5: flip pending
        acc = 0; nw = 0; maxlvl = 0; prev_we = 1'b1;
        for (int i = 0; i < 80; i++) begin
            vld = (acc < 6);
            cmd_valid = vld; cmd_type = 2'b00; cmd_data = 18'((acc + 1) << 6);
            frame_start = (i == 12);
            if (i == 11) begin
                n_chk++; if (fifo_level !== 5'd4 || cmd_ready !== 1'b0)
                    $display("FAIL full_state got level=%0h ready=%0h exp 4 0", fifo_level, cmd_ready); else n_ok++;
                n_chk++; if (acc !== 4)          $display("FAIL full_accepted got %0d exp 4", acc); else n_ok++;
            end
            rdy = cmd_ready;
            tick();
            if (vld && rdy) acc++;
            if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
            if (!sram_we_n && prev_we) begin
                n_chk++; if (sram_addr !== 18'h20000 + 18'(nw) || sram_dq_out !== 24'((nw + 1) << 5))
                    $display("FAIL b2b_write%0d got addr=%0h dq=%0h exp %0h %0h", nw, sram_addr, sram_dq_out,
                             18'h20000 + 18'(nw), 24'((nw + 1) << 5)); else n_ok++;
                nw++;
            end
            prev_we = sram_we_n;
        end
        cmd_valid = 1'b0; frame_start = 1'b0;
        n_chk++; if (acc !== 6)    $display("FAIL b2b_accepted got %0d exp 6", acc); else n_ok++;
        n_chk++; if (nw !== 6)     $display("FAIL b2b_writes got %0d exp 6", nw); else n_ok++;
        n_chk++; if (maxlvl !== 4) $display("FAIL b2b_max_level got %0d exp 4", maxlvl); else n_ok++;
    endtask

    task automatic test_read();
        do_reset();
        rd_addr = 17'h00010;
        sram_dq_in = 24'hAB1234;
        repeat (2) tick();                            // C2
        n_chk++; if (sram_addr !== 18'h20010) $display("FAIL rd_addr got %0h exp 20010", sram_addr); else n_ok++;
        n_chk++; if (sram_oe_n !== 1'b0 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0)
            $display("FAIL rd_p2 got oe_n=%0h we_n=%0h oe=%0h exp 0 1 0", sram_oe_n, sram_we_n, sram_dq_oe); else n_ok++;
        tick();                                       // C3
        n_chk++; if (sram_oe_n !== 1'b0 || rd_valid !== 1'b0)
            $display("FAIL rd_p3 got oe_n=%0h valid=%0h exp 0 0", sram_oe_n, rd_valid); else n_ok++;
        tick();                                       // C4
        n_chk++; if (rd_valid !== 1'b1 || rd_data !== 16'h1234)
            $display("FAIL rd_data got valid=%0h data=%0h exp 1 1234", rd_valid, rd_data); else n_ok++;
        n_chk++; if (sram_oe_n !== 1'b1)     $display("FAIL rd_oe_release got %0h exp 1", sram_oe_n); else n_ok++;
        tick();                                       // C5
        n_chk++; if (rd_valid !== 1'b0)      $display("FAIL rd_valid_pulse got %0h exp 0", rd_valid); else n_ok++;
    endtask

    task automatic test_flip_coincident();
        do_reset();
        push(2'b10, 18'd0);                           // -> C1
        repeat (3) tick();                            // C4: flip popped here
        frame_start = 1'b1;
        tick();                                       // C5
        frame_start = 1'b0;
        n_chk++; if (page !== 1'b0 || disp_enable !== 1'b0)
            $display("FAIL coinc_no_toggle got page=%0h disp=%0h exp 0 0", page, disp_enable); else n_ok++;
        push(2'b00, 18'h00000);                       // -> C6
        tick();                                       // C7
        frame_start = 1'b1;
        tick();                                       // C8
        frame_start = 1'b0;
        n_chk++; if (page !== 1'b1 || disp_enable !== 1'b1)
            $display("FAIL coinc_next_toggle got page=%0h disp=%0h exp 1 1", page, disp_enable); else n_ok++;
        n_chk++; if (sram_we_n !== 1'b0 || sram_addr !== 18'h20000)
            $display("FAIL coinc_write got we_n=%0h addr=%0h exp 0 20000", sram_we_n, sram_addr); else n_ok++;
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        push(2'b10, 18'd0);                           // -> C1
        push(2'b00, 18'h00FC0);                       // -> C2
        push(2'b00, 18'h00FC0);                       // -> C3
        repeat (2) tick();                            // C5
        frame_start = 1'b1;
        tick();                                       // C6
        frame_start = 1'b0;
        n_chk++; if (page !== 1'b1)          $display("FAIL midrst_page_set got %0h exp 1", page); else n_ok++;
        repeat (3) tick();                            // C9: phase 1 of write
        n_chk++; if (sram_we_n !== 1'b0 || fifo_level !== 5'd1)
            $display("FAIL midrst_pre got we_n=%0h level=%0h exp 0 1", sram_we_n, fifo_level); else n_ok++;
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0)
            $display("FAIL midrst_strobe got we_n=%0h oe=%0h exp 1 0", sram_we_n, sram_dq_oe); else n_ok++;
        n_chk++; if (fifo_level !== 5'd0 || cmd_ready !== 1'b1)
            $display("FAIL midrst_fifo got level=%0h ready=%0h exp 0 1", fifo_level, cmd_ready); else n_ok++;
        do_reset();
        tick();
        n_chk++; if (page !== 1'b0 || disp_enable !== 1'b0 || sram_we_n !== 1'b1)
            $display("FAIL midrst_after got page=%0h disp=%0h we_n=%0h exp 0 0 1", page, disp_enable, sram_we_n); else n_ok++;
    endtask

    initial begin
        test_reset();
        test_addr_wrap();
        test_page_flip();
        test_back_to_back();
        test_read();
        test_flip_coincident();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule

// File: doc/sram_access_scheduler.md
SRAM_ACCESS_SCHEDULER -- requirements
Module: sram_access_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning command FIFO entries (power of two, 2..16).
REQ-002 SHALL have port mco, input, 1, the single system clock; all state SHALL change on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port cmd_valid, input, 1, command offered.
REQ-005 SHALL have port cmd_ready, output, 1, FIFO can accept.
REQ-006 SHALL have port cmd_type, input, 2: 00 data write, 01 address set, 10 page flip, 11 ignored.
REQ-007 SHALL have port cmd_data, input, 18, pixel {R6,G6,B6} or address.
REQ-008 SHALL have port frame_start, input, 1, one-cycle pulse at vertical sync start.
REQ-009 SHALL have port rd_addr, input, 17, display pixel index.
REQ-010 SHALL have ports rd_data, output, 16 and rd_valid, output, 1: fetched RGB565 pixel and its strobe.
REQ-011 SHALL have ports sram_addr, output, 18; sram_dq_out, output, 24; sram_dq_oe, output, 1; sram_dq_in, input, 24.
REQ-012 SHALL have ports sram_we_n, output, 1 and sram_oe_n, output, 1: active-low strobes.
REQ-013 SHALL have ports page, output, 1 (write page) and disp_enable, output, 1 (set after the first committed flip).
REQ-014 SHALL have port fifo_level, output, 5, current FIFO occupancy.

Function
REQ-015 Free-running 2-bit phase counter: 0 and 1 form the write slot, 2 and 3 the read slot, wrapping 3->0.
REQ-016 Push occurs when cmd_valid && cmd_ready; cmd_ready = (fifo_level != FIFO_DEPTH), with no push-through when full even on a same-cycle pop.
REQ-017 Commands with cmd_type 11 are accepted and discarded without being stored.
REQ-018 Pop occurs only in phase 0, FIFO non-empty, flip_pending = 0; a simultaneous push and pop leaves fifo_level unchanged.
REQ-019 Popping a data write: sram_addr = {page, wr_ptr}, sram_dq_out = {8'b0, d[5:1], d[11:6], d[17:13]}, sram_dq_oe = 1, sram_we_n = 0 for phases 0-1, then wr_ptr + 1.
REQ-020 wr_ptr is 17 bits and wraps from 131071 to 0.
REQ-021 Popping an address set: wr_ptr <= cmd_data[16:0]; no SRAM strobe in that slot.
REQ-022 Popping a page flip: flip_pending <= 1; no SRAM strobe in that slot.
REQ-023 While flip_pending = 1, no pops; commands continue to queue until full.
REQ-024 On frame_start with flip_pending already 1 at that edge: page toggles, flip_pending clears, disp_enable becomes 1 and stays 1.
REQ-025 frame_start with flip_pending = 0, including the same cycle the flip is popped, has no effect.
REQ-026 Read slot, every phase 2: sram_addr = {~page, rd_addr}, sram_dq_oe = 0, sram_we_n = 1, sram_oe_n = 0 for phases 2-3.
REQ-027 sram_dq_in is sampled at the edge ending phase 3; rd_data = sram_dq_in[15:0] and rd_valid = 1 for exactly the following phase-0 cycle.
REQ-028 sram_we_n and sram_oe_n are never both 0, and sram_dq_oe = 0 whenever sram_oe_n = 0.
REQ-029 Idle write slot: sram_we_n = 1, sram_dq_oe = 0, sram_addr holds its last value.

Reset
REQ-030 While rst_n = 0: phase 0, page 0, wr_ptr 0, FIFO empty, fifo_level 0, cmd_ready 1, flip_pending 0, disp_enable 0, sram_addr 0, sram_dq_out 0, sram_dq_oe 0, sram_we_n 1, sram_oe_n 1, rd_data 0, rd_valid 0.
REQ-031 Reset asserted mid-write or mid-read SHALL immediately deassert strobes and discard all queued commands.
REQ-032 After deassertion, the first write-slot opportunity is the first phase 0.

Verification
REQ-033 Address set 0x1FFFF, then two data writes 0x3FFFF -> writes at {0,0x1FFFF} then {0,0x00000}, dq 0x00FFFF, we_n low 2 cycles each.
REQ-034 Page flip, then data write, frame_start 10 cycles later -> write held until flip commits; page = 1, disp_enable = 1, write goes to address 0x20000.
REQ-035 Hold cmd_valid for 6 data writes, no pops (flip pending) -> cmd_ready 0 at fifo_level 4; 5th and 6th accepted only after drain.
REQ-036 rd_addr = 0x00010, page = 0, sram_dq_in = 0xAB1234 -> sram_addr 0x20010 with oe_n low in phases 2-3; rd_data 0x1234, rd_valid one cycle.
REQ-037 frame_start coincident with the flip-pop edge -> no toggle; the next frame_start toggles page.
REQ-038 Reset asserted during phase 1 of a write -> we_n 1 and FIFO empty in the same cycle; page 0 after release.
